// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, constants and types for the
// FPU datapath blocks.
package fp_pkg;

   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   // Bit positions inside flags = {invalid, div_by_zero, overflow, underflow}
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_DIV_ZERO  = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      DIVIDE,
      NORM_RND,
      DONE
   } state_e;

   typedef struct packed {
      logic is_zero;
      logic is_inf;
      logic is_nan;
   } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: zero (including flushed denormals),
// infinity and NaN. Only the magnitude bits are needed.
module fp_classify
   import fp_pkg::*;
(
   input  logic [EXP_W+MAN_W-1:0] mag_i,
   output logic                   is_zero_o,
   output logic                   is_inf_o,
   output logic                   is_nan_o
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;

   assign exp_f = mag_i[MAN_W +: EXP_W];
   assign man_f = mag_i[MAN_W-1:0];

   // Exponent field 0 covers true zero and denormals, which are flushed.
   assign is_zero_o = (exp_f == '0);
   assign is_inf_o  = (exp_f == '1) && (man_f == '0);
   assign is_nan_o  = (exp_f == '1) && (man_f != '0);

endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider, one restoring quotient bit per cycle.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncation.
module fp_div_seq
   import fp_pkg::*;
#(
   parameter int QBITS = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   localparam int CNT_W = $clog2(QBITS);
   localparam int REM_W = MAN_W + 2;

   state_e                  state_q, state_d;
   logic [31:0]             a_q, b_q;
   logic [REM_W-1:0]        rem_q;
   logic [QBITS-1:0]        q_q;
   logic [CNT_W-1:0]        cnt_q;
   logic signed [9:0]       e_q;
   logic [31:0]             result_q;
   logic [3:0]              flags_q;

   fp_class_t               cls_a, cls_b;
   logic                    sign, special;
   logic [REM_W-1:0]        divisor, rem_sub;
   logic                    q_bit;
   logic [MAN_W-1:0]        man, man_rnd;
   logic                    grd, rnd, sticky, inc, carry;
   logic signed [9:0]       e_norm, e_rnd;
   logic [31:0]             result_d;
   logic [3:0]              flags_d;

   fp_classify u_cls_a (
      .mag_i     (a_q[30:0]),
      .is_zero_o (cls_a.is_zero),
      .is_inf_o  (cls_a.is_inf),
      .is_nan_o  (cls_a.is_nan)
   );

   fp_classify u_cls_b (
      .mag_i     (b_q[30:0]),
      .is_zero_o (cls_b.is_zero),
      .is_inf_o  (cls_b.is_inf),
      .is_nan_o  (cls_b.is_nan)
   );

   assign sign    = a_q[31] ^ b_q[31];
   assign special = (|cls_a) | (|cls_b);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE:     state_d = start ? UNPACK : IDLE;
         UNPACK: begin
            busy    = 1'b1;
            state_d = special ? NORM_RND : DIVIDE;
         end
         DIVIDE: begin
            busy = 1'b1;
            if (cnt_q == CNT_W'(QBITS - 1)) state_d = NORM_RND;
         end
         NORM_RND: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? UNPACK : IDLE;
         end
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign divisor = {2'b01, b_q[MAN_W-1:0]};
   assign q_bit   = (rem_q >= divisor);
   assign rem_sub = q_bit ? (rem_q - divisor) : rem_q;

   // A quotient below 1 is normalised by one left shift; its round bit is then 0.
   always_comb begin
      e_norm = e_q;
      man    = q_q[QBITS-2 -: MAN_W];
      grd    = q_q[QBITS-2-MAN_W];
      rnd    = q_q[QBITS-3-MAN_W];
      if (!q_q[QBITS-1]) begin
         e_norm = e_q - 10'sd1;
         man    = q_q[QBITS-3 -: MAN_W];
         grd    = q_q[QBITS-3-MAN_W];
         rnd    = 1'b0;
      end
      sticky = |rem_q;
`ifdef ROUND_NEAREST_EN
      inc = grd & (rnd | sticky | man[0]);
`else
      inc = 1'b0;
`endif
      {carry, man_rnd} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
      e_rnd = carry ? (e_norm + 10'sd1) : e_norm;
   end

`ifndef ROUND_NEAREST_EN
   logic unused_round_bits;
   assign unused_round_bits = grd ^ rnd ^ sticky;
`endif

   always_comb begin
      result_d = {sign, e_rnd[EXP_W-1:0], man_rnd};
      flags_d  = '0;
      if (cls_a.is_nan || cls_b.is_nan ||
          (cls_a.is_zero && cls_b.is_zero) || (cls_a.is_inf && cls_b.is_inf)) begin
         result_d               = QNAN;
         flags_d[FLAG_INVALID]  = 1'b1;
      end else if (cls_b.is_zero && !cls_a.is_inf) begin
         result_d               = {sign, POS_INF[30:0]};
         flags_d[FLAG_DIV_ZERO] = 1'b1;
      end else if (cls_a.is_inf) begin
         result_d = {sign, POS_INF[30:0]};
      end else if (cls_b.is_inf || cls_a.is_zero) begin
         result_d = {sign, 31'h0};
      end else if (e_rnd >= 10'sd255) begin
         flags_d[FLAG_OVERFLOW] = 1'b1;
`ifdef ROUND_NEAREST_EN
         result_d = {sign, POS_INF[30:0]};
`else
         result_d = {sign, 31'h7F7F_FFFF};
`endif
      end else if (e_rnd <= 10'sd0) begin
         flags_d[FLAG_UNDERFLOW] = 1'b1;
         result_d                = {sign, 31'h0};
      end
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         e_q      <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q <= a;
                  b_q <= b;
               end
            end
            UNPACK: begin
               rem_q <= {2'b01, a_q[MAN_W-1:0]};
               q_q   <= '0;
               cnt_q <= '0;
               e_q   <= signed'({2'b00, a_q[30:23]}) - signed'({2'b00, b_q[30:23]})
                        + 10'(EXP_BIAS);
            end
            DIVIDE: begin
               rem_q <= {rem_sub[REM_W-2:0], 1'b0};
               q_q   <= {q_q[QBITS-2:0], q_bit};
               cnt_q <= cnt_q + CNT_W'(1);
            end
            NORM_RND: begin
               result_q <= result_d;
               flags_q  <= flags_d;
            end
            default: ;
         endcase
      end
   end

   assign result = result_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vector table, randomized ops
// against an integer-arithmetic reference model, and handshake corner cases.
module tb_fp_div_seq;

`ifdef ROUND_NEAREST_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   fp_div_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flags  (flags)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   // Reference: exact long division with 64-bit integers, then IEEE rounding.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] f,
                                 output bit sp);
      int ex, ey, e, k;
      bit zx, zy, ix, iy, nx, ny;
      logic s;
      longint unsigned num, den, q, rm, m, tail, half;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      zx = (ex == 0);
      zy = (ey == 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      s  = x[31] ^ y[31];
      f  = 4'b0000;
      sp = 1'b1;
      r  = 32'h0;
      if (nx || ny || (zx && zy) || (ix && iy)) begin
         r = 32'h7FC00000;
         f = 4'b1000;
      end else if (zy && !ix) begin
         r = {s, 31'h7F800000};
         f = 4'b0100;
      end else if (ix) begin
         r = {s, 31'h7F800000};
      end else if (iy || zx) begin
         r = {s, 31'h0};
      end else begin
         sp   = 1'b0;
         num  = longint'({1'b1, x[22:0]}) << 39;
         den  = longint'({1'b1, y[22:0]});
         q    = num / den;
         rm   = num % den;
         e    = ex - ey + 127;
         if (q >= (64'd1 << 39)) k = 16;
         else begin
            k = 15;
            e = e - 1;
         end
         m    = q >> k;
         tail = q & ((64'd1 << k) - 1);
         half = 64'd1 << (k - 1);
         if (RNE && (tail > half || (tail == half && (rm != 0 || m[0])))) m = m + 1;
         if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
         end
         if (e >= 255) begin
            f = 4'b0010;
            r = RNE ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
         end else if (e <= 0) begin
            f = 4'b0001;
            r = {s, 31'h0};
         end else begin
            r = {s, e[7:0], m[22:0]};
         end
      end
   endfunction

   // Counts edges after the accepting edge until done; -1 if it never comes.
   task automatic wait_done(output int lat, output bit busy_ok);
      lat     = -1;
      busy_ok = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            if (busy) busy_ok = 1'b0;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic run_op(input logic [31:0] aa, input logic [31:0] bb,
                         output logic [31:0] r, output logic [3:0] f,
                         output int lat, output bit busy_ok);
      @(negedge clk);
      a     = aa;
      b     = bb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      wait_done(lat, busy_ok);
      r = result;
      f = flags;
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      int          sel;
      v   = $urandom;
      sel = $urandom_range(0, 19);
      if (sel == 0)      v[30:23] = 8'h00;
      else if (sel == 1) begin
         v[30:23] = 8'hFF;
         v[22:0]  = 23'h0;
      end else if (sel == 2) v[30:23] = 8'hFF;
      else if (sel < 6)  v[30:23] = 8'($urandom_range(1, 12));
      else if (sel < 9)  v[30:23] = 8'($urandom_range(243, 254));
      else               v[30:23] = 8'($urandom_range(1, 254));
      return v;
   endfunction

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
   } vec_t;

   initial begin
      vec_t        vecs[14];
      logic [31:0] r, er;
      logic [3:0]  f, ef;
      int          lat, done_seen;
      bit          bok, sp;

      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28};
      vecs[1]  = '{32'h3F800000, 32'h40400000, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA, 4'b0000, 28};
      vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2};
      vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2};
      vecs[4]  = '{32'h7F7FFFFF, 32'h3F000000, RNE ? 32'h7F800000 : 32'h7F7FFFFF, 4'b0010, 28};
      vecs[5]  = '{32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001, 28};
      vecs[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2};
      vecs[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2};
      vecs[8]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 2};
      vecs[9]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 2};
      vecs[10] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 2};
      vecs[11] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 2};
      vecs[12] = '{32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000, 28};
      vecs[13] = '{32'h7F800000, 32'h80000000, 32'hFF800000, 4'b0000, 2};

      rst   = 1'b1;
      start = 1'b0;
      a     = 32'h0;
      b     = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check("reset_result", result, 32'h0);
      check("reset_flags", {28'h0, flags}, 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, r, f, lat, bok);
         check($sformatf("vec%0d_result", i), r, vecs[i].res);
         check($sformatf("vec%0d_flags", i), {28'h0, f}, {28'h0, vecs[i].flg});
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_busy", i), {31'h0, bok}, 32'h1);
      end

      for (int n = 0; n < 300; n++) begin
         logic [31:0] ra, rb;
         ra = rand_operand();
         rb = rand_operand();
         model(ra, rb, er, ef, sp);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         run_op(ra, rb, r, f, lat, bok);
         check($sformatf("rand%0d_result(%08h/%08h)", n, ra, rb), r, er);
         check($sformatf("rand%0d_flags", n), {28'h0, f}, {28'h0, ef});
         check($sformatf("rand%0d_latency", n), lat, sp ? 2 : 28);
         check($sformatf("rand%0d_busy", n), {31'h0, bok}, 32'h1);
      end

      // Start mid-operation is ignored; start while done is accepted.
      @(negedge clk);
      a     = 32'h40C00000;
      b     = 32'h40000000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 5) begin
            start = 1'b1;
            a     = 32'h3F800000;
            b     = 32'h40400000;
         end
         if (i == 6) start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
      check("ignored_start_latency", lat, 28);
      check("ignored_start_result", result, 32'h40400000);
      check("ignored_start_flags", {28'h0, flags}, 32'h0);

      a     = 32'h3F800000;
      b     = 32'h40400000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_accept_busy", {31'h0, busy}, 32'h1);
      check("b2b_accept_done", {31'h0, done}, 32'h0);
      wait_done(lat, bok);
      check("b2b_latency", lat, 28);
      check("b2b_result", result, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA);
      @(posedge clk);
      #1;
      check("done_pulse_width", {31'h0, done}, 32'h0);
      check("idle_busy", {31'h0, busy}, 32'h0);

      // Reset in the middle of a divide aborts it with no later done.
      @(negedge clk);
      a     = 32'h40C00000;
      b     = 32'h40000000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_done", {31'h0, done}, 32'h0);
      check("midrst_result", result, 32'h0);
      check("midrst_flags", {28'h0, flags}, 32'h0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) done_seen++;
      end
      check("midrst_no_stale_done", done_seen, 0);

      run_op(32'h40C00000, 32'h40000000, r, f, lat, bok);
      check("after_rst_result", r, 32'h40400000);
      check("after_rst_latency", lat, 28);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
